// File: rtl/regfile_fwd_multi_pkg.sv
// Shared constants for the decode-stage register file: CPU default widths and FSM state codes.
package regfile_fwd_multi_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

endpackage

// File: rtl/regfile_rd_mux.sv
// One read port: zero-register check, prioritised bypass chain, WB write-through, array fallback.
module regfile_rd_mux
  import regfile_fwd_multi_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_FWD  = 2,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0]         raddr,
  input  logic [DATA_W-1:0]         arr_data,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [NUM_FWD-1:0]        fwd_wreg,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
  output logic [DATA_W-1:0]         rdata
);

  // Sources are applied lowest priority first so each later assignment overrides.
  // NOTE: rdata gets a default before any conditional so no latch is inferred.
  always_comb begin
    rdata = arr_data;
    if (we && (waddr == raddr)) rdata = wdata;
    for (int s = NUM_FWD - 1; s >= 0; s--) begin
      if (fwd_wreg[s] && (fwd_waddr[s*ADDR_W +: ADDR_W] == raddr))
        rdata = fwd_wdata[s*DATA_W +: DATA_W];
    end
    if ((ZERO_REG != 0) && (raddr == '0)) rdata = '0;
  end

endmodule

// File: rtl/regfile_fwd_multi.sv
// Multi-port register file with bypass, write-through and a sequential post-reset clear (busy while clearing).
module regfile_fwd_multi
  import regfile_fwd_multi_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int NUM_FWD  = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_RD*ADDR_W-1:0]  raddr,
  output logic [NUM_RD*DATA_W-1:0]  rdata,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [NUM_FWD-1:0]        fwd_wreg,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
  output logic                      busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else if (state == ST_CLEAR) begin
      clr_ptr <= clr_ptr + ADDR_W'(1);
      if (&clr_ptr) state <= ST_RUN;
    end
  end

  // NOTE: the array has no reset; it is zeroed one entry per cycle by the CLEAR walk instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_CLEAR)
        mem[clr_ptr] <= '0;
      else if (we && !((ZERO_REG != 0) && (waddr == '0)))
        mem[waddr] <= wdata;
    end
  end

  assign busy = (state == ST_CLEAR);

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] port_addr;
    logic [DATA_W-1:0] port_data;

    assign port_addr = raddr[p*ADDR_W +: ADDR_W];

    regfile_rd_mux #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NUM_FWD (NUM_FWD),
      .ZERO_REG(ZERO_REG)
    ) u_rd_mux (
      .raddr    (port_addr),
      .arr_data (mem[port_addr]),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .fwd_wreg (fwd_wreg),
      .fwd_waddr(fwd_waddr),
      .fwd_wdata(fwd_wdata),
      .rdata    (port_data)
    );

    // Until the clear completes the array content is not trusted, so every port reads zero.
    assign rdata[p*DATA_W +: DATA_W] = busy ? '0 : port_data;
  end

endmodule

// File: tb/tb_regfile_fwd_multi.sv
// Bench for regfile_fwd_multi: one ZERO_REG=1 and one ZERO_REG=0 instance on shared stimulus, checked against a behavioural model.
module tb_regfile_fwd_multi;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NF = 2;
  localparam int DEPTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata_z, rdata_n;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [DW-1:0]    wdata;
  logic [NF-1:0]    fwd_wreg;
  logic [NF*AW-1:0] fwd_waddr;
  logic [NF*DW-1:0] fwd_wdata;
  logic             busy_z, busy_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_fwd_multi #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_FWD(NF), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_z), .we(we), .waddr(waddr), .wdata(wdata),
    .fwd_wreg(fwd_wreg), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .busy(busy_z)
  );

  regfile_fwd_multi #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_FWD(NF), .ZERO_REG(0)) dut_n (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_n), .we(we), .waddr(waddr), .wdata(wdata),
    .fwd_wreg(fwd_wreg), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .busy(busy_n)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a reset zeroes the whole array at once and starts a DEPTH-edge blackout; the
  // outside world cannot tell that apart from an entry-by-entry walk.
  logic [DW-1:0] mz [DEPTH];
  logic [DW-1:0] mn [DEPTH];
  int clear_left = 0;
  bit model_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      clear_left  = DEPTH;
      model_valid = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        mz[i] = '0;
        mn[i] = '0;
      end
    end else if (clear_left > 0) begin
      clear_left--;
    end else if (we) begin
      mn[waddr] = wdata;
      if (waddr != 0) mz[waddr] = wdata;
    end
  end

  function automatic logic [DW-1:0] exp_read(input bit zr, input logic [AW-1:0] a);
    if (clear_left > 0) return '0;
    if (zr && a == 0) return '0;
    for (int s = 0; s < NF; s++)
      if (fwd_wreg[s] && fwd_waddr[s*AW +: AW] == a) return fwd_wdata[s*DW +: DW];
    if (we && waddr == a) return wdata;
    return zr ? mz[a] : mn[a];
  endfunction

  always @(negedge clk) begin
    if (model_valid) begin
      check("busy_z", {31'b0, busy_z}, {31'b0, clear_left > 0});
      check("busy_n", {31'b0, busy_n}, {31'b0, clear_left > 0});
      for (int p = 0; p < NR; p++) begin
        check("model_rdata_z", rdata_z[p*DW +: DW], exp_read(1'b1, raddr[p*AW +: AW]));
        check("model_rdata_n", rdata_n[p*DW +: DW], exp_read(1'b0, raddr[p*AW +: AW]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (busy_z === 1'b1 && n < 100) begin
      step();
      n++;
    end
    check(name, n, 32);
  endtask

  initial begin
    rst = 1'b1; raddr = '0; we = 1'b0; waddr = '0; wdata = '0;
    fwd_wreg = '0; fwd_waddr = '0; fwd_wdata = '0;

    // Reset held for two edges, then a full clear.
    step();
    step();
    check("busy_in_rst", {31'b0, busy_z}, 32'd1);
    rst = 1'b0;
    #1 check("rdata_in_clear", rdata_n[31:0], 32'h0);
    count_busy("clear_len_first");
    for (int a = 0; a < DEPTH; a++) begin
      raddr = {AW'(a ^ 31), AW'(a)};
      #1 check("post_clear_zero", rdata_n[31:0], 32'h0);
      step();
    end

    // Reset pulse mid-clear (pointer at 10) restarts; WB write during clear is dropped.
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    we = 1'b1; waddr = 5'd3; wdata = 32'h55; raddr = {5'd3, 5'd3};
    #1 check("wt_ignored_in_clear", rdata_n[31:0], 32'h0);
    count_busy("clear_len_restart");
    we = 1'b0; wdata = '0;
    #1 check("r3_after_clear", rdata_n[31:0], 32'h0);
    check("r3_after_clear_p1", rdata_z[63:32], 32'h0);

    // Write-through then array read.
    step();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr = {5'd0, 5'd5};
    #1 check("write_through_z", rdata_z[31:0], 32'hDEADBEEF);
    check("write_through_n", rdata_n[31:0], 32'hDEADBEEF);
    step();
    we = 1'b0; wdata = '0;
    #1 check("array_read_r5", rdata_z[31:0], 32'hDEADBEEF);

    // Bypass priority: fwd0 > fwd1 > write-through > array.
    step();
    fwd_wreg = 2'b11; fwd_waddr = {5'd7, 5'd7}; fwd_wdata = {32'h22, 32'h11};
    we = 1'b1; waddr = 5'd7; wdata = 32'h33; raddr = {5'd7, 5'd7};
    #1 check("fwd0_p0", rdata_z[31:0], 32'h11);
    check("fwd0_p1", rdata_z[63:32], 32'h11);
    fwd_wreg = 2'b10;
    #1 check("fwd1_p0", rdata_z[31:0], 32'h22);
    check("fwd1_p1", rdata_n[63:32], 32'h22);
    fwd_wreg = 2'b00;
    #1 check("wt_r7_p0", rdata_z[31:0], 32'h33);
    check("wt_r7_p1", rdata_z[63:32], 32'h33);
    step();
    we = 1'b0;
    #1 check("array_r7", rdata_n[63:32], 32'h33);

    // Entry 0 behaviour with and without the hard-wired zero register.
    step();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
    fwd_wreg = 2'b01; fwd_waddr = {5'd9, 5'd0}; fwd_wdata = {32'h0, 32'h1234};
    raddr = {5'd0, 5'd0};
    #1 check("r0_fwd_z", rdata_z[31:0], 32'h0);
    check("r0_fwd_n", rdata_n[31:0], 32'h1234);
    fwd_wreg = 2'b00;
    #1 check("r0_wt_z", rdata_z[63:32], 32'h0);
    check("r0_wt_n", rdata_n[63:32], 32'hFFFF_FFFF);
    step();
    we = 1'b0; wdata = '0;
    #1 check("r0_array_z", rdata_z[31:0], 32'h0);
    check("r0_array_n", rdata_n[31:0], 32'hFFFF_FFFF);

    // Second port reading another register while port 0 reads r0.
    raddr = {5'd5, 5'd0};
    #1 check("p1_r5", rdata_n[63:32], 32'hDEADBEEF);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
